// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard unit: result-select and
// forward-select encodings, FSM state enum and the control bundle.
package riscv_pipe_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } hz_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit bundle: register fields and enables in,
// forward selects and stall/flush controls out.
interface hazard_ctrl_if;

    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] Rs1E;
    logic [4:0] Rs2E;
    logic [4:0] RdE;
    logic [4:0] RdM;
    logic [4:0] RdW;
    logic       RegWriteM;
    logic       RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE;
    logic       MemReqM;
    logic       mem_ready;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
        output MemReqM, mem_ready,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE,
        input  MemReqM, mem_ready,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM, FlushD, FlushE
    );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// Operand bypass select for one Execute source; Memory beats Writeback.
module forward_unit
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    logic hit_m;
    logic hit_w;

    assign hit_m = reg_write_m && (rd_m != 5'd0) && (rd_m == rs);
    assign hit_w = reg_write_w && (rd_w != 5'd0) && (rd_w == rs);

    always_comb begin
        fwd_sel = FWD_RF;
        if (hit_m) begin
            fwd_sel = FWD_M;
        end else if (hit_w) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: forwarding, stall/flush arbitration, memory-wait FSM.
// Define HAZARD_PERF_CNT_EN to build the saturating performance counters.
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz,
    output logic          mem_timeout,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt,
    output logic [31:0]   wait_cnt
);

    localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

    logic      memstall;
    logic      lwstall;
    hz_ctrl_t  ctrl;

    hz_state_e   state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        tmo_q, tmo_d;

    forward_unit u_fwd_a (
        .rs          (hz.Rs1E),
        .rd_m        (hz.RdM),
        .rd_w        (hz.RdW),
        .reg_write_m (hz.RegWriteM),
        .reg_write_w (hz.RegWriteW),
        .fwd_sel     (hz.ForwardAE)
    );

    forward_unit u_fwd_b (
        .rs          (hz.Rs2E),
        .rd_m        (hz.RdM),
        .rd_w        (hz.RdW),
        .reg_write_m (hz.RegWriteM),
        .reg_write_w (hz.RegWriteW),
        .fwd_sel     (hz.ForwardBE)
    );

    assign memstall = hz.MemReqM && !hz.mem_ready;
    assign lwstall  = (hz.ResultSrcE == RES_LOAD) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    always_comb begin
        ctrl = '0;
        if (memstall) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.stall_m = 1'b1;
        end else if (hz.PCSrcE) begin
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end else if (lwstall) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end
    end

    assign hz.StallF = ctrl.stall_f;
    assign hz.StallD = ctrl.stall_d;
    assign hz.StallE = ctrl.stall_e;
    assign hz.StallM = ctrl.stall_m;
    assign hz.FlushD = ctrl.flush_d;
    assign hz.FlushE = ctrl.flush_e;

    // Wait counter only counts edges already spent in MEM_WAIT.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            RUN:      if (memstall)  state_d = MEM_WAIT;
            MEM_WAIT: if (!memstall) state_d = RUN;
        endcase
        if (state_d == RUN) begin
            wait_d = '0;
        end else if (state_q == MEM_WAIT && memstall && wait_q != TMO) begin
            wait_d = wait_q + 16'd1;
        end
        if (wait_d == TMO) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem_timeout = tmo_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (memstall) begin
            if (!(&wait_cnt_q)) wait_cnt_d = wait_cnt_q + 32'd1;
        end else if (hz.PCSrcE) begin
            if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 32'd1;
        end else if (lwstall) begin
            if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;
    import riscv_pipe_pkg::*;

    localparam int TMO = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_timeout;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: length of the current unbroken memstall run
    int      run_len;
    bit      m_tmo;
    longint  m_stall;
    longint  m_flush;
    longint  m_wait;

    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .hz          (hz),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .wait_cnt    (wait_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ms_ref();
        return hz.MemReqM && !hz.mem_ready;
    endfunction

    function automatic bit lw_ref();
        return hz.ResultSrcE == 2'b01 && hz.RdE != 0 &&
               (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    endfunction

    // {StallF, StallD, StallE, StallM, FlushD, FlushE}
    function automatic logic [5:0] ctl_ref();
        if (ms_ref())   return 6'b111100;
        if (hz.PCSrcE)  return 6'b000011;
        if (lw_ref())   return 6'b110001;
        return 6'b000000;
    endfunction

    task automatic check_comb(input string tag);
        check({tag, "_ctl"},
              {26'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
               hz.FlushD, hz.FlushE}, {26'd0, ctl_ref()});
        check({tag, "_fwdA"}, {30'd0, hz.ForwardAE}, {30'd0, fwd_ref(hz.Rs1E)});
        check({tag, "_fwdB"}, {30'd0, hz.ForwardBE}, {30'd0, fwd_ref(hz.Rs2E)});
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_tmo"}, {31'd0, mem_timeout}, {31'd0, m_tmo});
        check({tag, "_stallcnt"}, stall_cnt, PERF ? 32'(m_stall) : 32'd0);
        check({tag, "_flushcnt"}, flush_cnt, PERF ? 32'(m_flush) : 32'd0);
        check({tag, "_waitcnt"}, wait_cnt, PERF ? 32'(m_wait) : 32'd0);
    endtask

    task automatic model_reset();
        run_len = 0;
        m_tmo   = 1'b0;
        m_stall = 0;
        m_flush = 0;
        m_wait  = 0;
    endtask

    task automatic model_edge();
        if (ms_ref()) begin
            run_len++;
            m_wait++;
        end else begin
            run_len = 0;
            if (hz.PCSrcE) m_flush++;
            else if (lw_ref()) m_stall++;
        end
        // first memstall edge only enters the wait state
        if (run_len - 1 >= TMO) m_tmo = 1'b1;
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_comb(tag);
        @(posedge clk);
        model_edge();
        #1;
        check_seq(tag);
    endtask

    task automatic set_idle();
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
        hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0; hz.ResultSrcE = 2'b00;
        hz.PCSrcE = 0; hz.MemReqM = 0; hz.mem_ready = 0;
    endtask

    task automatic set_random();
        hz.Rs1D = 5'($urandom_range(0, 3));
        hz.Rs2D = 5'($urandom_range(0, 3));
        hz.Rs1E = 5'($urandom_range(0, 3));
        hz.Rs2E = 5'($urandom_range(0, 3));
        hz.RdE  = 5'($urandom_range(0, 3));
        hz.RdM  = 5'($urandom_range(0, 3));
        hz.RdW  = 5'($urandom_range(0, 3));
        hz.RegWriteM  = 1'($urandom);
        hz.RegWriteW  = 1'($urandom);
        hz.ResultSrcE = 2'($urandom);
        hz.PCSrcE     = ($urandom_range(0, 3) == 0);
        hz.MemReqM    = 1'($urandom);
        hz.mem_ready  = ($urandom_range(0, 3) == 0);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_seq(tag);
        check_comb(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        model_reset();
        #7;
        check_seq("reset");
        check_comb("reset");
        rst = 1'b0;

        hz.Rs1E = 5; hz.RdM = 5; hz.RdW = 5;
        hz.RegWriteM = 1; hz.RegWriteW = 1;
        #1;
        check("fwd_mem_prio", {30'd0, hz.ForwardAE}, 32'd2);
        step("fwd_m");
        hz.RdM = 0;
        #1;
        check("fwd_wb", {30'd0, hz.ForwardAE}, 32'd1);
        step("fwd_w");
        set_idle();

        hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
        step("ldu");
        hz.RdE = 0;
        step("ldu_next");

        hz.RdE = 7; hz.PCSrcE = 1;
        step("redir_ldu");
        set_idle();

        hz.MemReqM = 1;
        repeat (3) step("mwait");
        check("mwait_cnt", wait_cnt, PERF ? 32'd3 : 32'd0);
        hz.mem_ready = 1;
        step("mwait_rel");
        set_idle();
        step("idle");

        hz.MemReqM = 1;
        repeat (6) step("tmo");
        check("tmo_set", {31'd0, mem_timeout}, 32'd1);
        hz.mem_ready = 1;
        step("tmo_ready");
        set_idle();
        repeat (2) step("tmo_hold");

        hz.MemReqM = 1;
        repeat (2) step("rst_wait");
        async_reset("rst_mid");
        check("rst_tmo_now", {31'd0, mem_timeout}, 32'd0);
        repeat (3) step("rst_after");
        set_idle();

        for (int i = 0; i < 500; i++) begin
            set_random();
            step("rand");
            if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the number of MEM_WAIT cycles after which mem_timeout sets; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have ports Rs1D/Rs2D, input, 5 each, source registers of the instruction in Decode.
REQ-005 SHALL have ports Rs1E/Rs2E/RdE, input, 5 each, sources and destination of the instruction in Execute.
REQ-006 SHALL have ports RdM/RdW, input, 5 each, destinations in Memory and Writeback.
REQ-007 SHALL have ports RegWriteM/RegWriteW, input, 1 each, write enables in Memory and Writeback.
REQ-008 SHALL have port ResultSrcE, input, 2, result select in Execute; 2'b01 = load.
REQ-009 SHALL have port PCSrcE, input, 1, taken branch/jump/jalr resolved in Execute.
REQ-010 SHALL have ports MemReqM (input, 1, load/store in Memory) and mem_ready (input, 1, data memory completes this cycle).
REQ-011 SHALL have ports ForwardAE/ForwardBE, output, 2 each: 00 = register file, 01 = ResultW, 10 = ALUResultM.
REQ-012 SHALL have ports StallF/StallD/StallE/StallM and FlushD/FlushE, output, 1 each, pipeline-register controls.
REQ-013 SHALL have port mem_timeout, output, 1, sticky memory-timeout error.
REQ-014 SHALL have ports stall_cnt/flush_cnt/wait_cnt, output, 32 each, performance counters.

Function
REQ-015 ForwardAE SHALL be 10 if RegWriteM && RdM!=0 && RdM==Rs1E, else 01 if RegWriteW && RdW!=0 && RdW==Rs1E, else 00. ForwardBE is identical using Rs2E; Memory takes priority over Writeback.
REQ-016 memstall SHALL be MemReqM && !mem_ready, evaluated combinationally with zero-cycle latency.
REQ-017 lwstall SHALL be (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-018 Controls SHALL be resolved by priority: memstall > PCSrcE > lwstall.
REQ-019 When memstall is set, StallF, StallD, StallE and StallM SHALL be 1, and FlushD and FlushE SHALL be 0.
REQ-020 Otherwise, when PCSrcE is set, FlushD and FlushE SHALL be 1 and all stalls SHALL be 0. The redirect discards any load-use pair.
REQ-021 Otherwise, when lwstall is set, StallF, StallD and FlushE SHALL be 1 for exactly one cycle (bubble insertion).
REQ-022 When none of the above applies, all stall and flush outputs SHALL be 0.
REQ-023 The FSM SHALL have states RUN and MEM_WAIT. RUN moves to MEM_WAIT on memstall. MEM_WAIT moves to RUN on edges where memstall is 0. All other conditions hold the current state.
REQ-024 A wait counter SHALL clear on entry to RUN, increment on each edge in MEM_WAIT while memstall=1, and saturate at MEM_TIMEOUT.
REQ-025 mem_timeout SHALL set on the edge at which the wait counter reaches MEM_TIMEOUT and hold until rst. Stalls continue regardless of mem_timeout.
REQ-026 mem_ready=1 in MEM_WAIT SHALL release the stalls in that same cycle.

Reset
REQ-027 rst SHALL immediately force state=RUN, wait counter=0, mem_timeout=0 and all performance counters=0.
REQ-028 Combinational outputs SHALL follow REQ-015..022 during reset. rst asserted mid-wait SHALL abandon MEM_WAIT.

Configuration
REQ-029 With macro HAZARD_PERF_CNT_EN defined, the performance counters SHALL be built as follows, each 32-bit and saturating at 0xFFFFFFFF:
- stall_cnt increments each cycle lwstall wins arbitration.
- flush_cnt increments each cycle PCSrcE wins arbitration.
- wait_cnt increments each memstall cycle.
REQ-030 Without HAZARD_PERF_CNT_EN, the ports SHALL remain and be tied to 0, with no counter flops synthesized.

Structure
REQ-031 The shared package riscv_pipe_pkg SHALL hold the ResultSrc encodings, the forward-select encodings (FWD_RF/FWD_W/FWD_M) and the state enum {RUN, MEM_WAIT}.
REQ-032 One sub-module, forward_unit, SHALL compute the select for a single operand and be instantiated twice (A and B).

Verification
REQ-033 Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. With RdM=0 instead -> ForwardAE=01.
REQ-034 Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> one cycle of StallF=StallD=FlushE=1. Next cycle with RdE=0 -> all 0.
REQ-035 Redirect vs load-use: PCSrcE=1 and lwstall=1 together -> FlushD=FlushE=1, StallF=StallD=0, flush_cnt +1, stall_cnt unchanged.
REQ-036 Memory wait: MemReqM=1, mem_ready=0 for 3 cycles then 1 -> stalls asserted for 3 cycles, FSM in MEM_WAIT, wait_cnt=3, release on the ready cycle.
REQ-037 Timeout: MEM_TIMEOUT=4 with mem_ready held 0 -> mem_timeout=1 after the 4th wait edge, and stays 1 after ready returns, until rst.
REQ-038 Async reset mid-wait: assert rst between edges -> state=RUN, mem_timeout=0 and counters=0 immediately, without waiting for clk.
